// File: rtl/ascon_p_slice_ctrl_if.sv
// rtl/ascon_p_slice_ctrl_if.sv - stream and core-side bundle for the Ascon slice controller
//
// Purpose: groups the upstream state port, the downstream result port, the
//          watchdog flag and the slice-serial core port into one bundle.
// Modports:
//   master : the controller (drives in_ready, out_*, err, core_en, core_en_inc,
//            core_slice_idx, core_slice_in)
//   slave  : the environment (drives in_valid, in_state, out_ready,
//            core_slice_out, core_r, core_done)
// Signals:
//   in_valid/in_ready/in_state      upstream 320-bit state, x0 in the top BW bits
//   out_valid/out_ready/out_state   permuted state, same packing
//   err                             watchdog abort flag
//   core_en/core_en_inc             core slice write / round advance enables
//   core_slice_idx/core_slice_in    core slice select and write data
//   core_slice_out                  core read data, one cycle after idx
//   core_r/core_done                core round counter and finished flag

interface ascon_p_slice_ctrl_if #(
   parameter int BW = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [5*BW-1:0]   in_state;
   logic              out_valid;
   logic              out_ready;
   logic [5*BW-1:0]   out_state;
   logic              err;
   logic              core_en;
   logic              core_en_inc;
   logic [2:0]        core_slice_idx;
   logic [BW-1:0]     core_slice_in;
   logic [BW-1:0]     core_slice_out;
   logic [3:0]        core_r;
   logic              core_done;

   modport master (
      input  in_valid, in_state, out_ready, core_slice_out, core_r, core_done,
      output in_ready, out_valid, out_state, err,
             core_en, core_en_inc, core_slice_idx, core_slice_in
   );

   modport slave (
      output in_valid, in_state, out_ready, core_slice_out, core_r, core_done,
      input  in_ready, out_valid, out_state, err,
             core_en, core_en_inc, core_slice_idx, core_slice_in
   );
endinterface

// File: rtl/ascon_p_slice_ctrl.sv
// rtl/ascon_p_slice_ctrl.sv - controller that feeds, runs and drains a slice-serial Ascon-p core
//
// Purpose: accepts a 320-bit state, writes it into the core as 5 x BW slices,
//          lets the core run its 12 rounds, reads the 5 result slices back
//          and offers the permuted state downstream.
// Ports:
//   clk  : single clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : ascon_p_slice_ctrl_if.master (state in/out ports, err, core port)
// Optional feature: define ASCON_CTRL_TIMEOUT_EN to add a RUN-phase watchdog
//          of TMO_CYC cycles; on expiry err=1 and a zero state is offered.
//          Without it err is tied 0 and RUN waits for core_done indefinitely.

module ascon_p_slice_ctrl #(
   parameter int BW      = 64,
   parameter int NSLICE  = 5,
   parameter int TMO_CYC = 32
) (
   input logic                 clk,
   input logic                 rst,
   ascon_p_slice_ctrl_if.master bus
);
   localparam int         SW       = NSLICE * BW;
   localparam logic [2:0] LAST_IDX = 3'(NSLICE - 1);
   localparam logic [2:0] READ_END = 3'(NSLICE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_READ,
      S_OUT
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            first_q, first_d;
   logic [SW-1:0]   shadow_q, shadow_d;
   logic [SW-1:0]   out_state_q, out_state_d;
   logic            out_valid_q, out_valid_d;
   logic            en_q, en_d;
   logic            inc_q, inc_d;
   logic [2:0]      idx_q, idx_d;
   logic [BW-1:0]   sin_q, sin_d;

`ifdef ASCON_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0]   run_cnt_q, run_cnt_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      shadow_d    = shadow_q;
      out_state_d = out_state_q;
      out_valid_d = out_valid_q;
      // Core-side strobes default low each cycle so they are only high where set.
      en_d        = 1'b0;
      inc_d       = 1'b0;
      idx_d       = 3'd0;
      sin_d       = '0;
`ifdef ASCON_CTRL_TIMEOUT_EN
      run_cnt_d   = run_cnt_q;
      err_d       = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               // Slice 0 goes out on the accept edge; the shadow keeps the rest,
               // shifted so the next slice is always in the top BW bits.
               state_d  = S_LOAD;
               cnt_d    = 3'd0;
               en_d     = 1'b1;
               idx_d    = 3'd0;
               sin_d    = bus.in_state[SW-1 -: BW];
               shadow_d = bus.in_state << BW;
            end
         end

         S_LOAD: begin
            if (cnt_q == LAST_IDX) begin
               state_d   = S_RUN;
               inc_d     = 1'b1;
               first_d   = 1'b1;
`ifdef ASCON_CTRL_TIMEOUT_EN
               run_cnt_d = '0;
`endif
            end else begin
               cnt_d    = cnt_q + 3'd1;
               en_d     = 1'b1;
               idx_d    = cnt_q + 3'd1;
               sin_d    = shadow_q[SW-1 -: BW];
               shadow_d = shadow_q << BW;
            end
         end

         S_RUN: begin
            // core_done may still be high from the previous run during the
            // first RUN cycle, so it is only trusted from the second cycle on.
            first_d = 1'b0;
`ifdef ASCON_CTRL_TIMEOUT_EN
            run_cnt_d = run_cnt_q + 1'b1;
`endif
            if (!first_q && bus.core_done) begin
               state_d = S_READ;
               cnt_d   = 3'd0;
               idx_d   = 3'd0;
            end
`ifdef ASCON_CTRL_TIMEOUT_EN
            else if (run_cnt_q == TW'(TMO_CYC - 1)) begin
               state_d     = S_OUT;
               err_d       = 1'b1;
               out_valid_d = 1'b1;
               out_state_d = '0;
            end
`endif
            else begin
               inc_d = 1'b1;
            end
         end

         S_READ: begin
            // Index c is presented in cycle c; its data arrives in cycle c+1
            // and is shifted in from the bottom, so x0 ends up on top.
            cnt_d = cnt_q + 3'd1;
            if (cnt_q < LAST_IDX) begin
               idx_d = cnt_q + 3'd1;
            end
            if (cnt_q != 3'd0) begin
               out_state_d = {out_state_q[SW-BW-1:0], bus.core_slice_out};
            end
            if (cnt_q == READ_END) begin
               state_d     = S_OUT;
               cnt_d       = 3'd0;
               out_valid_d = 1'b1;
            end
         end

         S_OUT: begin
            if (bus.out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
`ifdef ASCON_CTRL_TIMEOUT_EN
               err_d       = 1'b0;
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         first_q     <= 1'b0;
         shadow_q    <= '0;
         out_state_q <= '0;
         out_valid_q <= 1'b0;
         en_q        <= 1'b0;
         inc_q       <= 1'b0;
         idx_q       <= 3'd0;
         sin_q       <= '0;
`ifdef ASCON_CTRL_TIMEOUT_EN
         run_cnt_q   <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         shadow_q    <= shadow_d;
         out_state_q <= out_state_d;
         out_valid_q <= out_valid_d;
         en_q        <= en_d;
         inc_q       <= inc_d;
         idx_q       <= idx_d;
         sin_q       <= sin_d;
`ifdef ASCON_CTRL_TIMEOUT_EN
         run_cnt_q   <= run_cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign bus.in_ready       = (state_q == S_IDLE);
   assign bus.out_valid      = out_valid_q;
   assign bus.out_state      = out_state_q;
   assign bus.core_en        = en_q;
   assign bus.core_en_inc    = inc_q;
   assign bus.core_slice_idx = idx_q;
   assign bus.core_slice_in  = sin_q;
`ifdef ASCON_CTRL_TIMEOUT_EN
   assign bus.err            = err_q;
`else
   assign bus.err            = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_p_slice_ctrl.sv
// tb/tb_ascon_p_slice_ctrl.sv - directed bench for the Ascon slice controller with a stub core

module tb_ascon_p_slice_ctrl;
   localparam int BW = 64;
   localparam int SW = 5 * BW;

   logic clk;
   logic rst;
   ascon_p_slice_ctrl_if #(.BW(BW)) bus ();

   ascon_p_slice_ctrl #(.BW(BW), .NSLICE(5), .TMO_CYC(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub core: each round adds (i+1) to slice i; done after 12 rounds.
   logic [BW-1:0] cs [5];
   logic [3:0]    r_q;
   logic          stale_done;
   logic          never_done;

   assign bus.core_r    = r_q;
   assign bus.core_done = stale_done | ((r_q == 4'd12) & ~never_done);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q                <= 4'd0;
         bus.core_slice_out <= '0;
      end else begin
         if (bus.core_en) begin
            if (bus.core_slice_idx < 3'd5) cs[bus.core_slice_idx] <= bus.core_slice_in;
            r_q <= 4'd0;
         end else if (bus.core_en_inc && !bus.core_done) begin
            r_q <= r_q + 4'd1;
            for (int i = 0; i < 5; i++) cs[i] <= cs[i] + 64'(i + 1);
         end
         bus.core_slice_out <= (bus.core_slice_idx < 3'd5) ? cs[bus.core_slice_idx] : '0;
      end
   end

   int checks;
   int errors;

   task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Counts edges until out_valid; lat starts at the value reached by the caller.
   task automatic wait_out(input int start, output int lat, output int incs, output logic rdy_low);
      lat     = start;
      incs    = 0;
      rdy_low = 1'b1;
      while (!bus.out_valid && lat < 200) begin
         tick();
         lat++;
         if (bus.core_en_inc) incs++;
         if (bus.in_ready)    rdy_low = 1'b0;
      end
   endtask

   task automatic accept(input logic [SW-1:0] st);
      bus.in_state = st;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   int   lat;
   int   incs;
   logic rdy_low;
   logic [SW-1:0] exp_state;

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      stale_done   = 1'b0;
      never_done   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_state = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_in_ready",  SW'(bus.in_ready), SW'(1));
      chk("rst_out_valid", SW'(bus.out_valid), SW'(0));
      chk("rst_core_en",   SW'(bus.core_en), SW'(0));
      chk("rst_en_inc",    SW'(bus.core_en_inc), SW'(0));
      chk("rst_idx",       SW'(bus.core_slice_idx), SW'(0));
      chk("rst_slice_in",  SW'(bus.core_slice_in), SW'(0));
      chk("rst_out_state", bus.out_state, SW'(0));
      chk("rst_err",       SW'(bus.err), SW'(0));
      rst = 1'b0;
      tick();

      // Load order x0..x4 = 1..5, then full run through the stub core
      accept({64'd1, 64'd2, 64'd3, 64'd4, 64'd5});
      chk("load_in_ready", SW'(bus.in_ready), SW'(0));
      for (int k = 0; k < 5; k++) begin
         if (k != 0) tick();
         chk("load_en",  SW'(bus.core_en), SW'(1));
         chk("load_idx", SW'(bus.core_slice_idx), SW'(k));
         chk("load_din", SW'(bus.core_slice_in), SW'(k + 1));
      end
      // Accept edge counts as 1; four more LOAD edges bring it to 5.
      wait_out(5, lat, incs, rdy_low);
      chk("run_latency",  SW'(lat), SW'(25));
      chk("run_inc_cyc",  SW'(incs), SW'(13));
      chk("run_rdy_low",  SW'(rdy_low), SW'(1));
      exp_state = {64'd13, 64'd26, 64'd39, 64'd52, 64'd65};
      chk("run_result",   bus.out_state, exp_state);

      // Backpressure: hold 10 cycles
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid",    SW'(bus.out_valid), SW'(1));
         chk("bp_state",    bus.out_state, exp_state);
         chk("bp_in_ready", SW'(bus.in_ready), SW'(0));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_release_valid", SW'(bus.out_valid), SW'(0));
      chk("bp_release_ready", SW'(bus.in_ready), SW'(1));

      // Reset in the middle of LOAD (k=2)
      accept({64'hAA, 64'hBB, 64'hCC, 64'hDD, 64'hEE});
      tick();
      tick();
      chk("mid_idx_before", SW'(bus.core_slice_idx), SW'(2));
      #2 rst = 1'b1;
      #1;
      chk("mid_core_en",   SW'(bus.core_en), SW'(0));
      chk("mid_idx",       SW'(bus.core_slice_idx), SW'(0));
      chk("mid_slice_in",  SW'(bus.core_slice_in), SW'(0));
      chk("mid_out_state", bus.out_state, SW'(0));
      chk("mid_in_ready",  SW'(bus.in_ready), SW'(1));
      tick();
      rst = 1'b0;
      chk("mid_ready_edge", SW'(bus.in_ready), SW'(1));
      tick();
      chk("mid_no_resume", SW'(bus.core_en), SW'(0));

      // Known answer with zero state
      accept('0);
      wait_out(1, lat, incs, rdy_low);
      chk("kat_latency", SW'(lat), SW'(25));
      chk("kat_result",  bus.out_state, {64'd12, 64'd24, 64'd36, 64'd48, 64'd60});
      chk("kat_err",     SW'(bus.err), SW'(0));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("kat_done_idle", SW'(bus.in_ready), SW'(1));

      // Stale done held high before start
      stale_done = 1'b1;
      exp_state  = {64'h1111, 64'h2222, 64'h3333, 64'h4444, 64'h5555};
      accept(exp_state);
      wait_out(1, lat, incs, rdy_low);
      chk("stale_inc_cyc", SW'(incs), SW'(2));
      chk("stale_latency", SW'(lat), SW'(14));
      chk("stale_result",  bus.out_state, exp_state);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      stale_done = 1'b0;
      chk("stale_idle", SW'(bus.in_ready), SW'(1));

`ifdef ASCON_CTRL_TIMEOUT_EN
      // Watchdog: core never finishes
      never_done = 1'b1;
      accept({64'd7, 64'd8, 64'd9, 64'd10, 64'd11});
      wait_out(1, lat, incs, rdy_low);
      chk("tmo_latency", SW'(lat), SW'(38));
      chk("tmo_inc_cyc", SW'(incs), SW'(32));
      chk("tmo_err",     SW'(bus.err), SW'(1));
      chk("tmo_state",   bus.out_state, SW'(0));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      never_done = 1'b0;
      chk("tmo_err_clear", SW'(bus.err), SW'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
